// File: rtl/control_unit_if.sv
// Bundle between the fetch/execute sequencer and the A/B datapath plus instruction memory.
// The master side is the sequencer; the slave side is the datapath/memory.
interface control_unit_if #(
    parameter int PC_W = 8
);
    logic            enable;
    logic [15:0]     instr;
    logic            alu_z;
    logic            alu_n;
    logic            alu_c;
    logic [PC_W-1:0] pc;
    logic            load_a;
    logic            load_b;
    logic [1:0]      sel_a;
    logic [1:0]      sel_b;
    logic [2:0]      alu_op;
    logic [7:0]      literal;
    logic [2:0]      flags;
    logic            halted;
    logic            illegal;

    modport master (
        input  enable, instr, alu_z, alu_n, alu_c,
        output pc, load_a, load_b, sel_a, sel_b, alu_op, literal, flags, halted, illegal
    );

    modport slave (
        output enable, instr, alu_z, alu_n, alu_c,
        input  pc, load_a, load_b, sel_a, sel_b, alu_op, literal, flags, halted, illegal
    );
endinterface

// File: rtl/control_unit.sv
// Two-cycle fetch/execute sequencer holding PC, IR and the Z/N/C flags.
// Strobes and selects are decoded combinationally from state and IR.
module control_unit #(
    parameter int          PC_W     = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic          clk,
    input  logic          reset,
    control_unit_if.master bus
);
    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC  = 2'b01,
        HALT  = 2'b10
    } state_t;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_MOVA = 8'h01;
    localparam logic [7:0] OP_MOVB = 8'h02;
    localparam logic [7:0] OP_MAB  = 8'h03;
    localparam logic [7:0] OP_MBA  = 8'h04;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_SUB  = 8'h06;
    localparam logic [7:0] OP_AND  = 8'h07;
    localparam logic [7:0] OP_OR   = 8'h08;
    localparam logic [7:0] OP_JMP  = 8'h09;
    localparam logic [7:0] OP_JEQ  = 8'h0A;
    localparam logic [7:0] OP_JNE  = 8'h0B;
    localparam logic [7:0] OP_JLT  = 8'h0C;
    localparam logic [7:0] OP_HLT  = 8'hFF;

    localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic [2:0]      flags_q, flags_d;

    logic [7:0] opcode;
    logic [7:0] lit;
    logic       loadA, loadB;
    logic [1:0] selA, selB;
    logic [2:0] aluOp;
    logic       aluWrite;
    logic       jumpTaken;
    logic       isIllegal;

    assign opcode = ir_q[15:8];
    assign lit    = ir_q[7:0];

    // Jumps look only at the registered flags, never at the live ALU inputs.
    always_comb begin
        loadA     = 1'b0;
        loadB     = 1'b0;
        selA      = 2'b00;
        selB      = 2'b00;
        aluOp     = 3'b000;
        aluWrite  = 1'b0;
        jumpTaken = 1'b0;
        isIllegal = 1'b0;
        if (state_q == EXEC) begin
            case (opcode)
                OP_NOP:  ;
                OP_MOVA: begin loadA = 1'b1; selA = 2'b01; end
                OP_MOVB: begin loadB = 1'b1; selB = 2'b01; end
                OP_MAB:  begin loadA = 1'b1; selA = 2'b10; end
                OP_MBA:  begin loadB = 1'b1; selB = 2'b10; end
                OP_ADD:  begin loadA = 1'b1; aluOp = 3'b000; aluWrite = 1'b1; end
                OP_SUB:  begin loadA = 1'b1; aluOp = 3'b001; aluWrite = 1'b1; end
                OP_AND:  begin loadA = 1'b1; aluOp = 3'b010; aluWrite = 1'b1; end
                OP_OR:   begin loadA = 1'b1; aluOp = 3'b011; aluWrite = 1'b1; end
                OP_JMP:  jumpTaken = 1'b1;
                OP_JEQ:  jumpTaken = flags_q[2];
                OP_JNE:  jumpTaken = ~flags_q[2];
                OP_JLT:  jumpTaken = flags_q[1];
                OP_HLT:  ;
                default: isIllegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        flags_d = flags_q;
        case (state_q)
            FETCH: begin
                if (bus.enable) begin
                    ir_d    = bus.instr;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (aluWrite) begin
                    flags_d = {bus.alu_z, bus.alu_n, bus.alu_c};
                end
                if (opcode == OP_HLT) begin
                    state_d = HALT;
                end else begin
                    state_d = FETCH;
                    pc_d    = jumpTaken ? PC_W'(lit) : pc_q + PC_W'(1);
                end
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC_V;
            ir_q    <= 16'h0000;
            flags_q <= 3'b000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
        end
    end

    assign bus.pc      = pc_q;
    assign bus.load_a  = loadA;
    assign bus.load_b  = loadB;
    assign bus.sel_a   = selA;
    assign bus.sel_b   = selB;
    assign bus.alu_op  = aluOp;
    assign bus.literal = lit;
    assign bus.flags   = flags_q;
    assign bus.halted  = (state_q == HALT);
    assign bus.illegal = isIllegal;
endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the stimulus pushes one hand-computed expected
// output record per clock cycle and a negedge monitor pops and compares it.
module tb_control_unit;
    logic clk;
    logic reset;

    control_unit_if #(.PC_W(8)) bus ();

    control_unit #(.PC_W(8), .RESET_PC(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] pc;
        logic       la;
        logic       lb;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [2:0] op;
        logic [7:0] lit;
        logic [2:0] flg;
        logic       hlt;
        logic       ill;
    } exp_t;

    exp_t  expQ[$];
    string nameQ[$];
    int    checks   = 0;
    int    failures = 0;
    logic [7:0] lastLit;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mkExp(input logic [7:0] pc, input logic la, input logic lb,
                                   input logic [1:0] sa, input logic [1:0] sb,
                                   input logic [2:0] op, input logic [7:0] lit,
                                   input logic [2:0] flg, input logic hlt, input logic ill);
        exp_t e;
        e.pc = pc; e.la = la; e.lb = lb; e.sa = sa; e.sb = sb;
        e.op = op; e.lit = lit; e.flg = flg; e.hlt = hlt; e.ill = ill;
        return e;
    endfunction

    task automatic checkOutput(input exp_t e, input string nm);
        exp_t act;
        act = mkExp(bus.pc, bus.load_a, bus.load_b, bus.sel_a, bus.sel_b,
                    bus.alu_op, bus.literal, bus.flags, bus.halted, bus.illegal);
        checks++;
        if (act !== e) begin
            failures++;
            $display("[TB] FAIL %s got pc=%h la=%b lb=%b sa=%b sb=%b op=%b lit=%h flg=%b hlt=%b ill=%b expected pc=%h la=%b lb=%b sa=%b sb=%b op=%b lit=%h flg=%b hlt=%b ill=%b",
                     nm, act.pc, act.la, act.lb, act.sa, act.sb, act.op, act.lit, act.flg, act.hlt, act.ill,
                     e.pc, e.la, e.lb, e.sa, e.sb, e.op, e.lit, e.flg, e.hlt, e.ill);
        end
    endtask

    // Drives one clock cycle of inputs and queues what the outputs must show in that cycle.
    task automatic applyStimulus(input logic rst, input logic en, input logic [15:0] ins,
                                 input logic [2:0] znc, input logic doCheck,
                                 input exp_t e, input string nm);
        @(posedge clk);
        #1;
        reset      = rst;
        bus.enable = en;
        bus.instr  = ins;
        bus.alu_z  = znc[2];
        bus.alu_n  = znc[1];
        bus.alu_c  = znc[0];
        if (doCheck) begin
            expQ.push_back(e);
            nameQ.push_back(nm);
        end
    endtask

    task automatic doInstr(input string nm, input logic [15:0] ins, input logic [7:0] pcE,
                           input logic [2:0] flgE, input logic la, input logic lb,
                           input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] op,
                           input logic ill, input logic [2:0] znc, input logic rstExec);
        applyStimulus(1'b0, 1'b1, ins, 3'b000, 1'b1,
                      mkExp(pcE, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, lastLit, flgE, 1'b0, 1'b0),
                      {nm, " fetch"});
        applyStimulus(rstExec, 1'b1, 16'hFFFF, znc, 1'b1,
                      mkExp(pcE, la, lb, sa, sb, op, ins[7:0], flgE, 1'b0, ill),
                      {nm, " exec"});
        lastLit = rstExec ? 8'h00 : ins[7:0];
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                checkOutput(expQ.pop_front(), nameQ.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t, expected run to finish earlier", $time);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        exp_t hltE;
        reset      = 1'b1;
        bus.enable = 1'b0;
        bus.instr  = 16'h0000;
        bus.alu_z  = 1'b0;
        bus.alu_n  = 1'b0;
        bus.alu_c  = 1'b0;
        lastLit    = 8'h00;
        repeat (2) @(posedge clk);

        //        name      instr     pc     flags   la    lb    sa     sb     op      ill   znc     rst
        doInstr("MOVA05", 16'h0105, 8'h00, 3'b000, 1'b1, 1'b0, 2'b01, 2'b00, 3'b000, 1'b0, 3'b000, 1'b0);
        doInstr("MOVAFF", 16'h01FF, 8'h01, 3'b000, 1'b1, 1'b0, 2'b01, 2'b00, 3'b000, 1'b0, 3'b000, 1'b0);
        doInstr("MOVB01", 16'h0201, 8'h02, 3'b000, 1'b0, 1'b1, 2'b00, 2'b01, 3'b000, 1'b0, 3'b000, 1'b0);
        doInstr("ADD",    16'h0500, 8'h03, 3'b000, 1'b1, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 3'b101, 1'b0);
        doInstr("JEQ40",  16'h0A40, 8'h04, 3'b101, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 3'b000, 1'b0);
        doInstr("MOVBA",  16'h0400, 8'h40, 3'b101, 1'b0, 1'b1, 2'b00, 2'b10, 3'b000, 1'b0, 3'b000, 1'b0);
        doInstr("MOVAB",  16'h0300, 8'h41, 3'b101, 1'b1, 1'b0, 2'b10, 2'b00, 3'b000, 1'b0, 3'b000, 1'b0);
        doInstr("SUB",    16'h0600, 8'h42, 3'b101, 1'b1, 1'b0, 2'b00, 2'b00, 3'b001, 1'b0, 3'b011, 1'b0);
        doInstr("JLT06",  16'h0C06, 8'h43, 3'b011, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 3'b000, 1'b0);
        doInstr("AND",    16'h0700, 8'h06, 3'b011, 1'b1, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0, 3'b100, 1'b0);
        doInstr("JNE20",  16'h0B20, 8'h07, 3'b100, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 3'b000, 1'b0);
        doInstr("OR",     16'h0800, 8'h08, 3'b100, 1'b1, 1'b0, 2'b00, 2'b00, 3'b011, 1'b0, 3'b010, 1'b0);
        doInstr("JEQ30",  16'h0A30, 8'h09, 3'b010, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 3'b000, 1'b0);
        doInstr("JNEFE",  16'h0BFE, 8'h0A, 3'b010, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 3'b000, 1'b0);
        doInstr("ILL37",  16'h3712, 8'hFE, 3'b010, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b1, 3'b000, 1'b0);
        doInstr("NOPFF",  16'h0000, 8'hFF, 3'b010, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 3'b000, 1'b0);
        doInstr("JMP03",  16'h0903, 8'h00, 3'b010, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 3'b000, 1'b0);

        // Stall in FETCH with junk on every input: nothing may move.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h01AA, 3'b111, 1'b1,
                          mkExp(8'h03, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 8'h03, 3'b010, 1'b0, 1'b0),
                          "stall");
        end

        doInstr("HLT",    16'hFF00, 8'h03, 3'b010, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 3'b000, 1'b0);
        hltE = mkExp(8'h03, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 8'h00, 3'b010, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b1, 16'h0105, 3'b111, 1'b1, hltE, "halted");
        end
        applyStimulus(1'b1, 1'b1, 16'h0105, 3'b000, 1'b1, hltE, "halt reset");
        lastLit = 8'h00;

        doInstr("ADD2",   16'h0500, 8'h00, 3'b000, 1'b1, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 3'b011, 1'b0);
        doInstr("SUBRST", 16'h0600, 8'h01, 3'b011, 1'b1, 1'b0, 2'b00, 2'b00, 3'b001, 1'b0, 3'b100, 1'b1);
        doInstr("MOVB55", 16'h0255, 8'h00, 3'b000, 1'b0, 1'b1, 2'b00, 2'b01, 3'b000, 1'b0, 3'b000, 1'b0);

        applyStimulus(1'b0, 1'b0, 16'h0000, 3'b000, 1'b0, hltE, "idle");
        applyStimulus(1'b0, 1'b0, 16'h0000, 3'b000, 1'b0, hltE, "idle");
        @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard drain got %0d pending entries, expected 0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle fetch/execute sequencer directly upstream of the 8-bit A/B data registers.
- Holds the PC and instruction register, and the Z/N/C flag register.
- Drives the load strobes and source selects of register A/B, the ALU op code and the literal bus.
- Instruction memory is external, combinational and indexed by pc.

Parameters:
- PC_W, 8, program counter width; pc wraps modulo 2^PC_W.
- RESET_PC, 0, pc value after reset.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run enable; low stalls the FSM in FETCH.
- instr  in  16  instruction at pc: opcode [15:8], literal [7:0].
- alu_z  in  1  ALU result zero (combinational, current A/B).
- alu_n  in  1  ALU result bit 7.
- alu_c  in  1  ALU carry-out / borrow.
- pc  out  PC_W  instruction address.
- load_a  out  1  register A load strobe.
- load_b  out  1  register B load strobe.
- sel_a  out  2  A source: 00 ALU, 01 literal, 10 B.
- sel_b  out  2  B source: 00 ALU, 01 literal, 10 A.
- alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR.
- literal  out  8  IR[7:0].
- flags  out  3  registered {Z,N,C}.
- halted  out  1  high in HALT state.
- illegal  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Reset: state=FETCH, pc=RESET_PC, IR=0, flags=0, halted=0; all strobes 0, sel_a/sel_b=00, alu_op=000. Reset wins over every other event in any state, including mid-EXEC and HALT.
- States: FETCH, EXEC, HALT.
  - FETCH: if enable, IR<=instr and go to EXEC; else hold all state. Strobes are 0 in FETCH.
  - EXEC: decoded outputs are asserted for exactly this one cycle; then go to FETCH, or to HALT for opcode 0xFF.
  - HALT: all strobes 0, halted=1; exit only by reset.
- Latency: every instruction takes 2 cycles. The target register is written on the clock edge ending EXEC.
- Outputs are combinational from state and IR. literal=IR[7:0] in all states.
- Opcodes (EXEC actions):
  - 0x00 NOP: no action.
  - 0x01 MOV A,lit: load_a, sel_a=01.
  - 0x02 MOV B,lit: load_b, sel_b=01.
  - 0x03 MOV A,B: load_a, sel_a=10.
  - 0x04 MOV B,A: load_b, sel_b=10.
  - 0x05–0x08 ADD/SUB/AND/OR: load_a, sel_a=00, alu_op=000/001/010/011. flags<={alu_z,alu_n,alu_c} on the same edge.
  - 0x09 JMP lit.
  - 0x0A JEQ lit: taken if Z=1.
  - 0x0B JNE lit: taken if Z=0.
  - 0x0C JLT lit: taken if N=1.
  - 0xFF HLT.
  - Any other opcode: behaves as NOP and illegal=1 for the EXEC cycle.
- Flags update only on ALU ops. MOV and jumps leave flags unchanged. Jumps test registered flags, i.e. the result of an earlier instruction, never the current ALU inputs.
- PC update at end of EXEC:
  - Taken jump: pc<=lit (zero-extended/truncated to PC_W).
  - HLT: pc holds.
  - Otherwise: pc<=pc+1, wrapping 2^PC_W−1 -> 0.
- enable is sampled only in FETCH. An EXEC already entered always completes.

Test Plan:
- Reset then MOV A,0x05 (0x0105) at pc 0 -> cycle 1 FETCH, cycle 2 load_a=1, sel_a=01, literal=0x05; pc=1 after.
- MOV A,0xFF; MOV B,0x01; ADD with alu_z=1, alu_c=1 driven -> flags=3'b101 after ADD EXEC; next JEQ 0x40 -> pc=0x40.
- JNE 0x20 with Z=1 at pc 7 -> not taken, pc=8, no strobes. JLT with N=1 -> pc=lit.
- pc at 0xFF executing NOP -> pc wraps to 0x00. Opcode 0x37 -> illegal pulses once, pc increments.
- HLT at pc 3 -> halted=1, pc stays 3 for 10+ cycles, strobes 0. Reset -> pc=0, halted=0.
- enable=0 for 5 cycles in FETCH -> pc/IR/flags frozen. Assert reset during an ADD EXEC -> no flag update, pc=0, state FETCH next cycle.
